muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit for the execute stage of the pipelined core. Covers all eight M-extension ops, selected by funct3.
- Sits beside the ALU. The hazard logic stalls decode/execute while busy_o is high, and the result is written back through the normal ALU-result path.
- Generalises the single-cycle ALU to a parametrised, multi-cycle operation with a start/busy/valid handshake and a flush.

Parameters:
- XLEN, 32, operand/result width; must be a power of 2 and at least 8.
- CNT_W, $clog2(XLEN), width of the iteration counter (derived; not overridden).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  request a new operation; accepted only when busy_o=0.
- op_i  in  3  muldiv_op_e: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (funct3 encoding 000..111).
- a_i  in  XLEN  rs1 operand; sampled on the accepting edge.
- b_i  in  XLEN  rs2 operand; sampled on the accepting edge.
- flush_i  in  1  abort any operation in flight (branch/jump flush).
- busy_o  out  1  high in CALC and FIX states.
- valid_o  out  1  one-cycle pulse marking result_o as valid.
- result_o  out  XLEN  result; held stable until the next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy_o=0, valid_o=0, result_o=0.
  - counter, accumulator, operand and sign registers all cleared.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start_i=1 and flush_i=0:
  - Latch op, the absolute values of the operands (per signedness of op), and the result sign.
  - Load counter with XLEN-1 and go to CALC.
  - Exception: divide special cases go straight to DONE (see below).
- CALC: one radix-2 step per cycle; counter decrements; on count 0 go to FIX.
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide/remainder: restoring division producing quotient and remainder.
- FIX:
  - Apply two's-complement negation if the latched sign requires it.
  - Select the product low half (MUL), product high half (MULH*), quotient (DIV*) or remainder (REM*).
  - Register into result_o; go to DONE.
- DONE: valid_o=1 for exactly this cycle. busy_o=0, so a new start in DONE is accepted (back-to-back). With no start, go to IDLE.
- Latency:
  - Start accepted on edge n gives valid_o high in the cycle after edge n+XLEN+1, i.e. XLEN+2 cycles (34 at XLEN=32).
  - Special cases: valid_o one cycle after the accepting edge.
- Signedness:
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU, DIVU, REMU: unsigned.
  - Remainder takes the sign of the dividend.
- Divide by zero (b=0): quotient all ones; remainder = a. 1-cycle fast path.
- Signed overflow (DIV/REM with a=INT_MIN, b=-1): quotient INT_MIN; remainder 0. 1-cycle fast path.
- start_i while busy_o=1: ignored; no queueing.
- flush_i=1 in any state:
  - Next state IDLE; valid_o stays 0 (a DONE-cycle pulse is suppressed); result_o keeps its last value.
  - flush_i and start_i together: flush wins, start is dropped.
- rst_n asserted mid-operation: immediate return to the reset state; no valid_o pulse.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a combinational 2*XLEN-bit multiplier. Path is IDLE→FIX→DONE, so valid_o comes 2 cycles after start. Divides are unchanged.
- Undefined: all multiplies use the iterative CALC path with XLEN+2 cycle latency. No hardware multiplier is inferred.

Decomposition:
- Add to types_pkg:
  - muldiv_op_e: 3-bit enum of the eight ops above.
  - muldiv_state_e: IDLE/CALC/FIX/DONE.
  - FUNCT7_MULDIV = 7'b000_0001 added to funct7_e.
- One combinational sub-module, muldiv_operand_prep: takes op and operands; outputs absolute-value operands, result-sign flag, div-by-zero flag and overflow flag.
- FSM, counter and datapath stay in muldiv_unit.

Test Plan:
- MUL, a=7, b=0xFFFFFFFD → result_o=0xFFFFFFEB; valid_o exactly 34 cycles after start; busy_o high for 33 cycles.
- MULH, a=b=0x80000000 → 0x40000000. MULHU, a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU, a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV, a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU, a=100, b=7 → 14; REMU same operands → 2.
- DIV, a=5, b=0 → 0xFFFFFFFF; REMU, a=5, b=0 → 5; DIV, a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM same operands → 0. Each with valid_o 1 cycle after start.
- Flush and reset mid-operation:
  - Start DIVU 100/7, assert flush_i 10 cycles later → busy_o=0 next cycle, no valid_o, result_o unchanged.
  - Then start MUL 3×4 → 12.
  - Assert rst_n=0 mid-CALC → all outputs 0 immediately.
- Back-to-back: MUL 2×3, then start MUL 5×6 in the DONE cycle → valid pulses carry 6 then 30, second 34 cycles after the first. start_i asserted while busy is ignored.

Source files
------------

// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
// Shared core types. Holds the RV32M multiply/divide op and FSM encodings,
// the funct7 values that select instruction groups, and small op-class
// helpers used by the multiply/divide unit.
// -----------------------------------------------------------------------------
package types_pkg;

  // funct7 field values for R-type instructions
  typedef enum logic [6:0] {
    FUNCT7_BASE   = 7'b000_0000,
    FUNCT7_MULDIV = 7'b000_0001,
    FUNCT7_ALT    = 7'b010_0000
  } funct7_e;

  // RV32M ops, encoded as their funct3
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// -----------------------------------------------------------------------------
// muldiv_operand_prep
// Combinational operand conditioning for muldiv_unit. Converts rs1/rs2 to
// magnitudes according to the signedness of the op, works out whether the
// final result must be negated, and flags the two divide special cases.
//
// Ports:
//   op_i        funct3 op code (muldiv_op_e)
//   a_i, b_i    raw rs1 / rs2 operands
//   abs_a_o     |a| (a itself when a is treated as unsigned)
//   abs_b_o     |b| (b itself when b is treated as unsigned)
//   neg_o       result needs two's-complement negation
//   div_zero_o  divide/remainder op with b == 0
//   overflow_o  signed DIV/REM with a == INT_MIN and b == -1
// -----------------------------------------------------------------------------
module muldiv_operand_prep
  import types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] abs_a_o,
  output logic [XLEN-1:0] abs_b_o,
  output logic            neg_o,
  output logic            div_zero_o,
  output logic            overflow_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_op_e op;
  logic       signed_a;
  logic       signed_b;
  logic       a_neg;
  logic       b_neg;

  assign op = muldiv_op_e'(op_i);

  always_comb begin
    // MUL keeps only the low half, which is identical for any signedness,
    // so it is handled as unsigned.
    signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = signed_a && a_i[XLEN-1];
    b_neg    = signed_b && b_i[XLEN-1];

    abs_a_o  = a_neg ? (~a_i + 1'b1) : a_i;
    abs_b_o  = b_neg ? (~b_i + 1'b1) : b_i;

    // Remainder follows the dividend's sign; everything else is the XOR.
    neg_o    = is_rem(op) ? a_neg : (a_neg ^ b_neg);

    div_zero_o = is_div(op) && (b_i == '0);
    overflow_o = ((op == OP_DIV) || (op == OP_REM)) && (a_i == INT_MIN) && (b_i == '1);
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit for the execute stage. One radix-2
// step per cycle: shift-add for multiplies, restoring division for
// divides/remainders. Operands are reduced to magnitudes up front and the
// sign is applied once in the FIX state.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   defined   - multiplies use a combinational 2*XLEN multiplier and skip
//               CALC (IDLE -> FIX -> DONE, valid 2 cycles after start)
//   undefined - all ops iterate through CALC (XLEN+2 cycle latency)
//
// Ports:
//   clk       core clock
//   rst_n     asynchronous active-low reset
//   start_i   request an op; accepted when busy_o is low
//   op_i      funct3 op code (muldiv_op_e)
//   a_i, b_i  rs1 / rs2, sampled on the accepting edge
//   flush_i   abort anything in flight, suppress a pending valid pulse
//   busy_o    high in CALC and FIX
//   valid_o   one-cycle pulse when result_o is new
//   result_o  result, held until the next accepted start completes
// -----------------------------------------------------------------------------
module muldiv_unit
  import types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] ST_IDLE = 2'(MD_IDLE);
  localparam logic [1:0] ST_CALC = 2'(MD_CALC);
  localparam logic [1:0] ST_FIX  = 2'(MD_FIX);
  localparam logic [1:0] ST_DONE = 2'(MD_DONE);

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic [1:0]        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  // Multiply: {product high, multiplier/product low}.
  // Divide:   {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0] prod_q,   prod_d;
  // Multiplicand for multiplies, divisor for divides.
  logic [XLEN-1:0]   mcand_q,  mcand_d;
  muldiv_op_e        op_q,     op_d;
  logic              neg_q,    neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  muldiv_op_e        op_in;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              neg_in;
  logic              div_zero;
  logic              overflow;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] fix_full;
  logic [XLEN-1:0]   fix_lo;
  logic [XLEN-1:0]   fix_hi;

  assign op_in = muldiv_op_e'(op_i);

  muldiv_operand_prep #(
    .XLEN (XLEN)
  ) u_prep (
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .abs_a_o    (abs_a),
    .abs_b_o    (abs_b),
    .neg_o      (neg_in),
    .div_zero_o (div_zero),
    .overflow_o (overflow)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = (2*XLEN)'(abs_a) * (2*XLEN)'(abs_b);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole product right by one.
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    // Restoring step: trial-subtract divisor from {remainder, next dividend bit}.
    div_diff = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]} - {1'b0, mcand_q};

    fix_full = neg_q ? (~prod_q + 1'b1) : prod_q;
    fix_lo   = neg_q ? (~prod_q[XLEN-1:0] + 1'b1) : prod_q[XLEN-1:0];
    fix_hi   = neg_q ? (~prod_q[2*XLEN-1:XLEN] + 1'b1) : prod_q[2*XLEN-1:XLEN];

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          op_d  = op_in;
          neg_d = neg_in;
          cnt_d = CNT_LAST;
          if (div_zero || overflow) begin
            // Special divides resolve immediately, no iteration.
            if (div_zero) result_d = is_rem(op_in) ? a_i : '1;
            else          result_d = is_rem(op_in) ? '0 : INT_MIN;
            state_d = ST_DONE;
          end else if (is_div(op_in)) begin
            prod_d  = {{XLEN{1'b0}}, abs_a};
            mcand_d = abs_b;
            state_d = ST_CALC;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            prod_d  = fast_prod;
            mcand_d = abs_a;
            state_d = ST_FIX;
`else
            prod_d  = {{XLEN{1'b0}}, abs_b};
            mcand_d = abs_a;
            state_d = ST_CALC;
`endif
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        if (is_div(op_q)) begin
          if (!div_diff[XLEN]) prod_d = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
          else                 prod_d = {prod_q[2*XLEN-2:0], 1'b0};
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
      end

      ST_FIX: begin
        case (op_q)
          OP_MUL:                       result_d = fix_full[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = fix_full[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:              result_d = fix_lo;
          default:                      result_d = fix_hi;
        endcase
        state_d = ST_DONE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything, including a simultaneous start, and must
    // not disturb the last delivered result.
    if (flush_i) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == ST_CALC) || (state_q == ST_FIX);
  // A flush landing in the DONE cycle cancels the pulse combinationally.
  assign valid_o  = (state_q == ST_DONE) && !flush_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int SPC_LAT = 1;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  logic            clk;
  logic            rst_n;
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait for its valid pulse. poke_at >= 1 drives a stray
  // start (MUL 3x4) on that cycle while the unit should be busy.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input string tag,
                        input int poke_at);
    int cyc;
    int busy_n;
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start_i = 1'b0; a_i = '0; b_i = '0;
    cyc = 1; busy_n = 0;
    while (valid_o !== 1'b1 && cyc < 200) begin
      if (busy_o === 1'b1) busy_n++;
      if (cyc == poke_at) begin
        start_i = 1'b1; op_i = MUL; a_i = 32'd3; b_i = 32'd4;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    chk({tag, "_valid"}, 64'(valid_o), 64'd1);
    chk({tag, "_result"}, 64'(result_o), 64'(exp_res));
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
  endtask

  initial begin
    int vcnt;
    rst_n = 1'b0; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_result", 64'(result_o), 64'd0);
    rst_n = 1'b1;

    // Multiplies
    run_op(MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7_m3", -1);
    @(negedge clk);
    chk("mul_pulse_width", 64'(valid_o), 64'd0);
    run_op(MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh_min", -1);
    run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max", -1);
    run_op(MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_m1_2", -1);

    // Divides, with a stray start while busy in the DIVU run
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, "div_m7_2", -1);
    run_op(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, "rem_m7_2", -1);
    run_op(DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, "divu_100_7_poke", 5);
    run_op(REMU, 32'd100, 32'd7, 32'd2, DIV_LAT, "remu_100_7", -1);

    // Special cases
    run_op(DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPC_LAT, "div_by_zero", -1);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, "div_ovf", -1);
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPC_LAT, "rem_ovf", -1);
    run_op(REMU, 32'd5, 32'd0, 32'd5, SPC_LAT, "remu_by_zero", -1);

    // Flush 10 cycles into a DIVU
    @(negedge clk);
    start_i = 1'b1; op_i = DIVU; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy", 64'(busy_o), 64'd0);
    chk("flush_valid", 64'(valid_o), 64'd0);
    chk("flush_result_kept", 64'(result_o), 64'd5);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o === 1'b1) vcnt++;
    end
    chk("flush_no_late_valid", 64'(vcnt), 64'd0);

    run_op(MUL, 32'd3, 32'd4, 32'd12, MUL_LAT, "mul_3_4", -1);

    // Start and flush together: start dropped
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = DIV; a_i = 32'd5; b_i = 32'd0;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_valid", 64'(valid_o), 64'd0);
    chk("flush_start_busy", 64'(busy_o), 64'd0);
    chk("flush_start_result", 64'(result_o), 64'd12);

    // Flush in the DONE cycle suppresses the pulse
    start_i = 1'b1; op_i = DIV; a_i = 32'd5; b_i = 32'd0;
    @(negedge clk);
    start_i = 1'b0;
    chk("done_valid_before_flush", 64'(valid_o), 64'd1);
    flush_i = 1'b1;
    #1;
    chk("done_flush_valid", 64'(valid_o), 64'd0);
    @(negedge clk);
    flush_i = 1'b0;
    chk("done_flush_idle_valid", 64'(valid_o), 64'd0);

    // Back-to-back: second start issued in the DONE cycle of the first
    run_op(MUL, 32'd2, 32'd3, 32'd6, MUL_LAT, "b2b_first", -1);
    start_i = 1'b1; op_i = MUL; a_i = 32'd5; b_i = 32'd6;
    begin
      int cyc;
      @(negedge clk);
      start_i = 1'b0;
      chk("b2b_busy_after_accept", 64'(busy_o), 64'd1);
      cyc = 1;
      while (valid_o !== 1'b1 && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("b2b_second_valid", 64'(valid_o), 64'd1);
      chk("b2b_second_result", 64'(result_o), 64'd30);
      chk("b2b_spacing", 64'(cyc), 64'(MUL_LAT));
    end

    // Reset in the middle of CALC
    @(negedge clk);
    start_i = 1'b1; op_i = DIVU; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 64'(busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_result", 64'(result_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o === 1'b1) vcnt++;
    end
    chk("midrst_no_valid", 64'(vcnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
